// File: rtl/display_mode_ctrl.sv
// Front-panel sequencer: three button pulses drive display mode, clock/timer edit buffers and counter commands.
// All outputs are registered and update on the edge that samples a button. There is no backpressure.
module display_mode_ctrl #(
  parameter int unsigned HOUR_MAX       = 23,
  parameter int unsigned MIN_MAX        = 59,
  parameter int unsigned SEC_MAX        = 59,
  parameter int unsigned TIMEOUT_CYCLES = 1500000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_select,
  input  logic        btn_inc,
  input  logic [23:0] data_ch,
  input  logic [23:0] data_t,
  output logic [1:0]  rezhim,
  output logic [1:0]  setup_rezhim_t,
  output logic [23:0] setup_data,
  output logic [23:0] setup_data_t,
  output logic        load_time,
  output logic        load_timer,
  output logic        sw_start_stop,
  output logic        sw_clear
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] H_LIM = 8'(HOUR_MAX);
  localparam logic [7:0] M_LIM = 8'(MIN_MAX);
  localparam logic [7:0] S_LIM = 8'(SEC_MAX);

  typedef enum logic [3:0] {
    ST_CLOCK,
    ST_SET_H,
    ST_SET_M,
    ST_SET_S,
    ST_TIMER,
    ST_TSET_H,
    ST_TSET_M,
    ST_TSET_S,
    ST_STOPWATCH
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [23:0]   sd_nxt, sdt_nxt;
  logic [1:0]    rezhim_nxt, srt_nxt;
  logic          lt_nxt, ltr_nxt, ss_nxt, clr_nxt;
  logic          any_btn, in_edit, timeout, abort;

  // Out-of-range values (e.g. a corrupted counter) wrap to zero just like the max value.
  function automatic logic [7:0] bump(input logic [7:0] f, input logic [7:0] lim);
    return (f >= lim) ? 8'd0 : f + 8'd1;
  endfunction

  assign any_btn = btn_mode | btn_select | btn_inc;
  assign in_edit = (state == ST_SET_H)  || (state == ST_SET_M)  || (state == ST_SET_S) ||
                   (state == ST_TSET_H) || (state == ST_TSET_M) || (state == ST_TSET_S);
  assign timeout = in_edit && !any_btn && (cnt == CNT_LAST);
  assign abort   = btn_mode || timeout;

  always_comb begin
    state_nxt = state;
    sd_nxt    = setup_data;
    sdt_nxt   = setup_data_t;
    lt_nxt    = 1'b0;
    ltr_nxt   = 1'b0;
    ss_nxt    = 1'b0;
    clr_nxt   = 1'b0;

    case (state)
      ST_CLOCK: begin
        if (btn_mode) begin
          state_nxt = ST_TIMER;
        end else if (btn_select) begin
          state_nxt = ST_SET_H;
          sd_nxt    = data_ch;
        end
      end
      ST_SET_H: begin
        if (abort)           state_nxt = ST_CLOCK;
        else if (btn_select) state_nxt = ST_SET_M;
        else if (btn_inc)    sd_nxt[23:16] = bump(setup_data[23:16], H_LIM);
      end
      ST_SET_M: begin
        if (abort)           state_nxt = ST_CLOCK;
        else if (btn_select) state_nxt = ST_SET_S;
        else if (btn_inc)    sd_nxt[15:8] = bump(setup_data[15:8], M_LIM);
      end
      ST_SET_S: begin
        if (abort) begin
          state_nxt = ST_CLOCK;
        end else if (btn_select) begin
          state_nxt = ST_CLOCK;
          lt_nxt    = 1'b1;
        end else if (btn_inc) begin
          sd_nxt[7:0] = bump(setup_data[7:0], S_LIM);
        end
      end
      ST_TIMER: begin
        if (btn_mode) begin
          state_nxt = ST_STOPWATCH;
        end else if (btn_select) begin
          state_nxt = ST_TSET_H;
          sdt_nxt   = data_t;
        end
      end
      ST_TSET_H: begin
        if (abort)           state_nxt = ST_TIMER;
        else if (btn_select) state_nxt = ST_TSET_M;
        else if (btn_inc)    sdt_nxt[23:16] = bump(setup_data_t[23:16], H_LIM);
      end
      ST_TSET_M: begin
        if (abort)           state_nxt = ST_TIMER;
        else if (btn_select) state_nxt = ST_TSET_S;
        else if (btn_inc)    sdt_nxt[15:8] = bump(setup_data_t[15:8], M_LIM);
      end
      ST_TSET_S: begin
        if (abort) begin
          state_nxt = ST_TIMER;
        end else if (btn_select) begin
          state_nxt = ST_TIMER;
          ltr_nxt   = 1'b1;
        end else if (btn_inc) begin
          sdt_nxt[7:0] = bump(setup_data_t[7:0], S_LIM);
        end
      end
      ST_STOPWATCH: begin
        if (btn_mode)        state_nxt = ST_CLOCK;
        else if (btn_select) ss_nxt    = 1'b1;
        else if (btn_inc)    clr_nxt   = 1'b1;
      end
      default: state_nxt = ST_CLOCK;
    endcase

    // Idle counter restarts on any press or state change and sits at zero outside edit.
    cnt_nxt = (in_edit && !any_btn && (state_nxt == state)) ? cnt + CW'(1) : '0;

    rezhim_nxt = 2'd0;
    srt_nxt    = 2'd0;
    case (state_nxt)
      ST_SET_H, ST_SET_M, ST_SET_S: rezhim_nxt = 2'd3;
      ST_TIMER:     rezhim_nxt = 2'd1;
      ST_TSET_H: begin rezhim_nxt = 2'd1; srt_nxt = 2'd1; end
      ST_TSET_M: begin rezhim_nxt = 2'd1; srt_nxt = 2'd2; end
      ST_TSET_S: begin rezhim_nxt = 2'd1; srt_nxt = 2'd3; end
      ST_STOPWATCH: rezhim_nxt = 2'd2;
      default:      rezhim_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_CLOCK;
      cnt            <= '0;
      rezhim         <= 2'd0;
      setup_rezhim_t <= 2'd0;
      setup_data     <= 24'd0;
      setup_data_t   <= 24'd0;
      load_time      <= 1'b0;
      load_timer     <= 1'b0;
      sw_start_stop  <= 1'b0;
      sw_clear       <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      rezhim         <= rezhim_nxt;
      setup_rezhim_t <= srt_nxt;
      setup_data     <= sd_nxt;
      setup_data_t   <= sdt_nxt;
      load_time      <= lt_nxt;
      load_timer     <= ltr_nxt;
      sw_start_stop  <= ss_nxt;
      sw_clear       <= clr_nxt;
    end
  end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Bench for display_mode_ctrl: a per-cycle behavioural model feeds an expected-output queue
// that an independent monitor drains and compares against the DUT.
module tb_display_mode_ctrl;

  localparam int T = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        btn_mode = 1'b0, btn_select = 1'b0, btn_inc = 1'b0;
  logic [23:0] data_ch = 24'd0, data_t = 24'd0;
  logic [1:0]  rezhim, setup_rezhim_t;
  logic [23:0] setup_data, setup_data_t;
  logic        load_time, load_timer, sw_start_stop, sw_clear;

  display_mode_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_mode       (btn_mode),
    .btn_select     (btn_select),
    .btn_inc        (btn_inc),
    .data_ch        (data_ch),
    .data_t         (data_t),
    .rezhim         (rezhim),
    .setup_rezhim_t (setup_rezhim_t),
    .setup_data     (setup_data),
    .setup_data_t   (setup_data_t),
    .load_time      (load_time),
    .load_timer     (load_timer),
    .sw_start_stop  (sw_start_stop),
    .sw_clear       (sw_clear)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  rz;
    logic [1:0]  rzt;
    logic [23:0] sd;
    logic [23:0] sdt;
    logic        lt;
    logic        ltr;
    logic        ss;
    logic        clr;
  } obs_t;

  obs_t cur_obs;
  assign cur_obs = {rezhim, setup_rezhim_t, setup_data, setup_data_t,
                    load_time, load_timer, sw_start_stop, sw_clear};

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model: display mode 0/1/2 (clock/timer/stopwatch), edit field 0 (none) or 1..3 (h/m/s).
  int m_mode, m_ed, m_idle;
  int buf_c[3], buf_t[3];
  int lim[3] = '{23, 59, 59};
  bit p_lt, p_ltr, p_ss, p_clr;

  function void chk(input string name, input obs_t act, input obs_t exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s @%0t: got rz=%0d rzt=%0d sd=%h sdt=%h lt=%b ltr=%b ss=%b clr=%b, expected rz=%0d rzt=%0d sd=%h sdt=%h lt=%b ltr=%b ss=%b clr=%b",
               name, $time, act.rz, act.rzt, act.sd, act.sdt, act.lt, act.ltr, act.ss, act.clr,
               exp_v.rz, exp_v.rzt, exp_v.sd, exp_v.sdt, exp_v.lt, exp_v.ltr, exp_v.ss, exp_v.clr);
    end
  endfunction

  function void model_reset();
    m_mode = 0; m_ed = 0; m_idle = 0;
    for (int k = 0; k < 3; k++) begin buf_c[k] = 0; buf_t[k] = 0; end
    p_lt = 0; p_ltr = 0; p_ss = 0; p_clr = 0;
  endfunction

  function obs_t model_obs();
    obs_t o;
    o.rz  = (m_mode == 0 && m_ed != 0) ? 2'd3 : 2'(m_mode);
    o.rzt = (m_mode == 1) ? 2'(m_ed) : 2'd0;
    o.sd  = {8'(buf_c[0]), 8'(buf_c[1]), 8'(buf_c[2])};
    o.sdt = {8'(buf_t[0]), 8'(buf_t[1]), 8'(buf_t[2])};
    o.lt  = p_lt;  o.ltr = p_ltr;
    o.ss  = p_ss;  o.clr = p_clr;
    return o;
  endfunction

  function void model_step(input bit m, input bit s, input bit i);
    p_lt = 0; p_ltr = 0; p_ss = 0; p_clr = 0;
    if (m_ed != 0) begin
      if (m || s || i) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == T) begin m_ed = 0; m_idle = 0; return; end
      end
    end
    if (m) begin
      if (m_ed != 0) m_ed = 0;
      else m_mode = (m_mode + 1) % 3;
    end else if (s) begin
      if (m_mode == 2) p_ss = 1;
      else if (m_ed == 0) begin
        m_ed = 1;
        for (int k = 0; k < 3; k++) begin
          if (m_mode == 0) buf_c[k] = int'((data_ch >> (16 - 8 * k)) & 24'hFF);
          else             buf_t[k] = int'((data_t  >> (16 - 8 * k)) & 24'hFF);
        end
      end else if (m_ed == 3) begin
        m_ed = 0;
        if (m_mode == 0) p_lt = 1; else p_ltr = 1;
      end else m_ed++;
    end else if (i) begin
      if (m_mode == 2) p_clr = 1;
      else if (m_ed != 0) begin
        if (m_mode == 0) buf_c[m_ed-1] = (buf_c[m_ed-1] >= lim[m_ed-1]) ? 0 : buf_c[m_ed-1] + 1;
        else             buf_t[m_ed-1] = (buf_t[m_ed-1] >= lim[m_ed-1]) ? 0 : buf_t[m_ed-1] + 1;
      end
    end
    if (m_ed == 0) m_idle = 0;
  endfunction

  // One clock of stimulus: buttons are high for exactly one sampling edge.
  task automatic cyc(input bit m, input bit s, input bit i);
    @(negedge clock);
    btn_mode = m; btn_select = s; btn_inc = i;
    model_step(m, s, i);
    exp_q.push_back(model_obs());
    @(posedge clock);
    #2;
    btn_mode = 1'b0; btn_select = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0);
  endtask

  function automatic logic [7:0] rfield();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 8'hFF;
    if (r < 3)  return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 63));
  endfunction

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cycle", cur_obs, e);
      end
    end
  end

  initial begin : driver
    model_reset();
    repeat (3) @(posedge clock);
    #1 chk("reset_state", cur_obs, model_obs());
    @(negedge clock) reset = 1'b1;

    // Mode rotation.
    repeat (4) cyc(1, 0, 0);
    repeat (2) cyc(1, 0, 0);
    idle(2);

    // Clock set with every field wrapping from its maximum.
    data_ch = 24'h173B3B;
    cyc(0, 1, 0); cyc(0, 0, 1); cyc(0, 1, 0); cyc(0, 0, 1);
    cyc(0, 1, 0); cyc(0, 0, 1); cyc(0, 1, 0);
    idle(2);

    // Timer set: minutes 5 -> 8.
    cyc(1, 0, 0);
    data_t = 24'h000500;
    cyc(0, 1, 0); cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 1);
    cyc(0, 1, 0); cyc(0, 1, 0);
    idle(2);

    // Stopwatch commands, then back to clock.
    cyc(1, 0, 0);
    cyc(0, 1, 0); cyc(0, 0, 1); idle(1);
    cyc(1, 0, 0);

    // Simultaneous mode+inc in SET_M aborts without touching minutes.
    data_ch = 24'h0A1E14;
    cyc(0, 1, 0); cyc(0, 1, 0); cyc(1, 0, 1);
    idle(2);

    // Idle timeout, then timeout restarted by an inc.
    cyc(0, 1, 0); idle(T + 2);
    cyc(0, 1, 0); idle(9); cyc(0, 0, 1); idle(T + 2);

    // Timer edit timeout, then back to clock.
    cyc(1, 0, 0); data_t = 24'h010203;
    cyc(0, 1, 0); idle(T + 2);
    cyc(1, 0, 0); cyc(1, 0, 0);

    // Reset asserted mid-edit.
    data_ch = 24'h051020;
    cyc(0, 1, 0); cyc(0, 0, 1); cyc(0, 1, 0);
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_reset_mid_edit", cur_obs, model_obs());
    @(negedge clock) reset = 1'b1;
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit m, s, i;
      m = 0; s = 0; i = 0;
      if ($urandom_range(0, 3) == 0) begin
        data_ch = {rfield(), rfield(), rfield()};
        data_t  = {rfield(), rfield(), rfield()};
      end
      if ($urandom_range(0, 4) == 0) begin
        m = ($urandom_range(0, 4) == 0);
        s = ($urandom_range(0, 1) == 1);
        i = ($urandom_range(0, 1) == 1);
      end
      cyc(m, s, i);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
